micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_pkg.sv | 49 ++++
 rtl/micro_sequencer_decoder.sv | 127 ++++++++++++
 rtl/micro_sequencer.sv | 116 +++++++++++
 tb/tb_micro_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg
//   Shared definitions for the multi-cycle RISC-V control sequencer:
//   state encoding, the opcode constants of the supported instruction
//   classes, the ALU operand-B / ALU-op encodings and the control word
//   that the decoder drives and the top level exposes.
package micro_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // ALU operand B select
  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  // ALU operation
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;   // 0 = PC, 1 = A
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/micro_sequencer_decoder.sv
// micro_decoder
//   Purely combinational decode of (state, opcode, mem_ready, bcond,
//   halt_req) into the datapath control word and the proposed next state.
//   The memory wait timeout is applied by the caller on top of this.
// Ports:
//   i_state        current sequencer state
//   i_opcode       IR[6:0]
//   i_mem_ready    memory completes the current access this cycle
//   i_bcond        branch-taken flag (meaningful in EX)
//   i_halt_req     ECALL halt condition (meaningful in EX)
//   o_ctrl         control word for the datapath
//   o_next_state   next state ignoring the wait timeout
module micro_decoder
  import micro_sequencer_pkg::*;
#(
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  state_t     i_state,
  input  logic [6:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_bcond,
  input  logic       i_halt_req,
  output ctrl_t      o_ctrl,
  output state_t     o_next_state
);

  always_comb begin
    o_ctrl       = '0;
    o_next_state = i_state;
    case (i_state)
      S_IF: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ir_write = i_mem_ready;
        if (i_mem_ready) o_next_state = S_ID;
      end
      S_ID: o_next_state = S_EX;
      S_EX: begin
        case (i_opcode)
          OP_R, OP_I: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = (i_opcode == OP_R) ? SRCB_B : SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_FUNCT;
            o_next_state     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_next_state     = S_MEM;
          end
          OP_BRANCH: begin
            o_ctrl.alu_src_b = i_bcond ? SRCB_IMM : SRCB_FOUR;
            o_ctrl.pc_write  = 1'b1;
            o_next_state     = S_IF;
          end
          OP_JAL, OP_JALR: begin
            // ALUOut <= PC+4 as the link value written back in WB
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_next_state     = S_WB;
          end
          OP_ECALL: begin
            if (i_halt_req) begin
              o_next_state = S_HALT;
            end else begin
              o_ctrl.alu_src_b = SRCB_FOUR;
              o_ctrl.pc_write  = 1'b1;
              o_next_state     = S_IF;
            end
          end
          default: begin
            if (HALT_ON_ILLEGAL != 0) begin
              o_next_state = S_FAULT;
            end else begin
              o_ctrl.alu_src_b = SRCB_FOUR;
              o_ctrl.pc_write  = 1'b1;
              o_next_state     = S_IF;
            end
          end
        endcase
      end
      S_MEM: begin
        case (i_opcode)
          OP_LOAD: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.i_or_d   = 1'b1;
            if (i_mem_ready) o_next_state = S_WB;
          end
          OP_STORE: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.i_or_d    = 1'b1;
            if (i_mem_ready) begin
              o_ctrl.alu_src_b = SRCB_FOUR;
              o_ctrl.pc_write  = 1'b1;
              o_next_state     = S_IF;
            end
          end
          // IR changed under a memory access: nothing sane to do
          default: o_next_state = S_FAULT;
        endcase
      end
      S_WB: begin
        case (i_opcode)
          OP_R, OP_I, OP_LOAD: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = (i_opcode == OP_LOAD);
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.pc_write   = 1'b1;
            o_next_state      = S_IF;
          end
          OP_JAL, OP_JALR: begin
            // target = PC+imm (JAL) or A+imm (JALR)
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_src_a = (i_opcode == OP_JALR);
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.pc_write  = 1'b1;
            o_next_state     = S_IF;
          end
          default: o_next_state = S_FAULT;
        endcase
      end
      S_HALT:  o_next_state = S_HALT;
      S_FAULT: o_next_state = S_FAULT;
      default: o_next_state = S_FAULT;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Multi-cycle control sequencer (IF/ID/EX/MEM/WB) with sticky HALT and
//   FAULT states and a memory wait timeout. Holds the state register, the
//   wait counter and the status flags; decode lives in micro_decoder.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   opcode               IR[6:0]
//   mem_ready            memory completes the current access
//   bcond, halt_req      branch-taken / ECALL-halt, valid in EX
//   pc_write .. alu_op   datapath controls
//   state                current state (debug)
//   halted, fault        sticky status flags
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 16,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       bcond,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       halted,
  output logic       fault
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_next_state;
  state_t            w_dec_next_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_halted;
  logic              r_fault;
  ctrl_t             w_ctrl;
  logic              w_mem_phase;
  logic              w_timeout;

  micro_decoder #(
    .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
  ) u_decoder (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .i_bcond     (bcond),
    .i_halt_req  (halt_req),
    .o_ctrl      (w_ctrl),
    .o_next_state(w_dec_next_state)
  );

  assign w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);
  // This cycle would be wait number MEM_TIMEOUT; mem_ready high still rescues it.
  assign w_timeout   = w_mem_phase && !mem_ready && (r_wait == WAIT_LAST);

  always_comb begin
    w_next_state = w_dec_next_state;
    if (w_timeout) w_next_state = S_FAULT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next_state;
  end

  // Every entry into IF/MEM comes from a non-memory state or with
  // mem_ready=1, so clearing there also clears on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (!w_mem_phase || mem_ready) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_halted <= r_halted | (w_next_state == S_HALT);
      r_fault  <= r_fault  | (w_next_state == S_FAULT);
    end
  end

  assign pc_write   = w_ctrl.pc_write;
  assign i_or_d     = w_ctrl.i_or_d;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign ir_write   = w_ctrl.ir_write;
  assign reg_write  = w_ctrl.reg_write;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign alu_op     = w_ctrl.alu_op;
  assign state      = r_state;
  assign halted     = r_halted;
  assign fault      = r_fault;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer
//   Directed bench for micro_sequencer. Main instance: MEM_TIMEOUT=4,
//   HALT_ON_ILLEGAL=1. Second instance: HALT_ON_ILLEGAL=0, shares inputs.
//   Control words are packed {pc_write,i_or_d,mem_read,mem_write,
//   mem_to_reg,ir_write,reg_write,alu_src_a,alu_src_b[1:0],alu_op[1:0]}.
module tb_micro_sequencer;
  import micro_sequencer_pkg::*;

  localparam logic [11:0] CW_ZERO     = 12'h000;
  localparam logic [11:0] CW_IF_RDY   = 12'h240;
  localparam logic [11:0] CW_IF_WAIT  = 12'h200;
  localparam logic [11:0] CW_EX_R     = 12'h012;
  localparam logic [11:0] CW_EX_I     = 12'h01A;
  localparam logic [11:0] CW_EX_LS    = 12'h018;
  localparam logic [11:0] CW_BR_TAKEN = 12'h808;
  localparam logic [11:0] CW_PC4      = 12'h804;
  localparam logic [11:0] CW_EX_J     = 12'h004;
  localparam logic [11:0] CW_MEM_LD   = 12'h600;
  localparam logic [11:0] CW_ST_WAIT  = 12'h500;
  localparam logic [11:0] CW_ST_DONE  = 12'hD04;
  localparam logic [11:0] CW_WB_ALU   = 12'h824;
  localparam logic [11:0] CW_WB_LD    = 12'h8A4;
  localparam logic [11:0] CW_WB_JAL   = 12'h828;
  localparam logic [11:0] CW_WB_JALR  = 12'h838;

  logic       clk, reset, mem_ready, bcond, halt_req;
  logic [6:0] opcode;
  logic       pc_write, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic [2:0] state;
  logic       halted, fault;
  logic       n_pc_write, n_i_or_d, n_mem_read, n_mem_write, n_mem_to_reg, n_ir_write, n_reg_write, n_alu_src_a;
  logic [1:0] n_alu_src_b, n_alu_op;
  logic [2:0] n_state;
  logic       n_halted, n_fault;
  logic [11:0] obs, obs_n;
  int total = 0;
  int bad   = 0;

  assign obs   = {pc_write, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write, alu_src_a, alu_src_b, alu_op};
  assign obs_n = {n_pc_write, n_i_or_d, n_mem_read, n_mem_write, n_mem_to_reg, n_ir_write, n_reg_write, n_alu_src_a, n_alu_src_b, n_alu_op};

  micro_sequencer #(.MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .bcond(bcond), .halt_req(halt_req),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .halted(halted), .fault(fault)
  );

  micro_sequencer #(.MEM_TIMEOUT(16), .HALT_ON_ILLEGAL(0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .bcond(bcond), .halt_req(halt_req),
    .pc_write(n_pc_write), .i_or_d(n_i_or_d), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .mem_to_reg(n_mem_to_reg), .ir_write(n_ir_write), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .state(n_state), .halted(n_halted), .fault(n_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after a rising edge, DUTs in IF.
  task automatic apply_reset();
    reset = 1'b1; mem_ready = 1'b0; bcond = 1'b0; halt_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; bcond = 1'b0; halt_req = 1'b0; opcode = 7'b1111111;
    #3;  // before any clock edge
    total++;
    if (state !== S_IF || obs !== CW_IF_WAIT || halted !== 1'b0 || fault !== 1'b0) begin
      bad++; $display("FAIL reset_idle state=%0d ctrl=%03h h=%b f=%b expected state=%0d ctrl=%03h h=0 f=0", state, obs, halted, fault, S_IF, CW_IF_WAIT);
    end
    mem_ready = 1'b1; #1;
    total++;
    if (obs !== CW_IF_RDY) begin
      bad++; $display("FAIL reset_irw ctrl=%03h expected %03h", obs, CW_IF_RDY);
    end
    @(posedge clk); #1; reset = 1'b0;
    // illegal opcode drives the main instance into FAULT
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (state !== S_FAULT || fault !== 1'b1) begin
      bad++; $display("FAIL reset_pre_fault state=%0d f=%b expected state=%0d f=1", state, fault, S_FAULT);
    end
    #2 reset = 1'b1; #1;  // no clock edge in between
    total++;
    if (state !== S_IF || fault !== 1'b0 || halted !== 1'b0 || obs !== CW_IF_RDY) begin
      bad++; $display("FAIL reset_async state=%0d f=%b ctrl=%03h expected state=%0d f=0 ctrl=%03h", state, fault, obs, S_IF, CW_IF_RDY);
    end
    @(posedge clk); #1; reset = 1'b0;
    $display("reset: idle values and asynchronous clear out of FAULT checked");
  endtask

  task automatic test_alu(input logic [6:0] opc, input logic [11:0] ex_cw, input string name);
    state_t      es [5] = '{S_IF, S_ID, S_EX, S_WB, S_IF};
    logic [11:0] ec [5];
    ec = '{CW_IF_RDY, CW_ZERO, ex_cw, CW_WB_ALU, CW_IF_RDY};
    apply_reset(); opcode = opc; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i]) begin
        bad++; $display("FAIL %s cyc=%0d state=%0d ctrl=%03h expected state=%0d ctrl=%03h", name, i, state, obs, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
    $display("%s: IF,ID,EX,WB then IF at cycle 4", name);
  endtask

  task automatic test_load_wait();
    state_t      es [9] = '{S_IF, S_ID, S_EX, S_MEM, S_MEM, S_MEM, S_MEM, S_WB, S_IF};
    logic [11:0] ec [9] = '{CW_IF_RDY, CW_ZERO, CW_EX_LS, CW_MEM_LD, CW_MEM_LD, CW_MEM_LD, CW_MEM_LD, CW_WB_LD, CW_IF_RDY};
    logic        rd [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset(); opcode = 7'b0000011;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i] || fault !== 1'b0) begin
        bad++; $display("FAIL load cyc=%0d state=%0d ctrl=%03h f=%b expected state=%0d ctrl=%03h f=0", i, state, obs, fault, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
    $display("load: MEM held 4 cycles with 3 wait cycles, WB writes memory data");
  endtask

  task automatic test_store();
    state_t      es [5] = '{S_IF, S_ID, S_EX, S_MEM, S_IF};
    logic [11:0] ec [5] = '{CW_IF_RDY, CW_ZERO, CW_EX_LS, CW_ST_DONE, CW_IF_RDY};
    apply_reset(); opcode = 7'b0100011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i]) begin
        bad++; $display("FAIL store cyc=%0d state=%0d ctrl=%03h expected state=%0d ctrl=%03h", i, state, obs, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
    $display("store: IF,ID,EX,MEM with PC+4 on completion");
  endtask

  task automatic test_branch(input logic taken, input logic [11:0] ex_cw);
    state_t      es [4] = '{S_IF, S_ID, S_EX, S_IF};
    logic [11:0] ec [4];
    ec = '{CW_IF_RDY, CW_ZERO, ex_cw, CW_IF_RDY};
    apply_reset(); opcode = 7'b1100011; mem_ready = 1'b1; bcond = taken;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i]) begin
        bad++; $display("FAIL branch_b%0d cyc=%0d state=%0d ctrl=%03h expected state=%0d ctrl=%03h", taken, i, state, obs, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
    $display("branch bcond=%0d: 3-cycle sequence", taken);
  endtask

  task automatic test_jump(input logic [6:0] opc, input logic [11:0] wb_cw, input string name);
    state_t      es [5] = '{S_IF, S_ID, S_EX, S_WB, S_IF};
    logic [11:0] ec [5];
    ec = '{CW_IF_RDY, CW_ZERO, CW_EX_J, wb_cw, CW_IF_RDY};
    apply_reset(); opcode = opc; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i]) begin
        bad++; $display("FAIL %s cyc=%0d state=%0d ctrl=%03h expected state=%0d ctrl=%03h", name, i, state, obs, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
    $display("%s: link in EX, target in WB", name);
  endtask

  task automatic test_ecall();
    state_t      es [6] = '{S_IF, S_ID, S_EX, S_HALT, S_HALT, S_HALT};
    logic [11:0] ec [6] = '{CW_IF_RDY, CW_ZERO, CW_ZERO, CW_ZERO, CW_ZERO, CW_ZERO};
    logic        eh [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    // no halt request: behaves as PC+4
    apply_reset(); opcode = 7'b1110011; mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk); total++;
    if (state !== S_EX || obs !== CW_PC4) begin
      bad++; $display("FAIL ecall_nohalt state=%0d ctrl=%03h expected state=%0d ctrl=%03h", state, obs, S_EX, CW_PC4);
    end
    @(posedge clk); #1;
    @(negedge clk); total++;
    if (state !== S_IF || halted !== 1'b0) begin
      bad++; $display("FAIL ecall_nohalt_ret state=%0d h=%b expected state=%0d h=0", state, halted, S_IF);
    end
    apply_reset(); opcode = 7'b1110011; mem_ready = 1'b1; halt_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i] || halted !== eh[i]) begin
        bad++; $display("FAIL ecall_halt cyc=%0d state=%0d ctrl=%03h h=%b expected state=%0d ctrl=%03h h=%b", i, state, obs, halted, es[i], ec[i], eh[i]);
      end
      @(posedge clk); #1;
    end
    halt_req = 1'b0;
    $display("ecall: PC+4 without request, sticky HALT with request");
  endtask

  task automatic test_illegal();
    state_t      es [5] = '{S_IF, S_ID, S_EX, S_FAULT, S_FAULT};
    logic [11:0] ec [5] = '{CW_IF_RDY, CW_ZERO, CW_ZERO, CW_ZERO, CW_ZERO};
    logic        ef [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    state_t      ns [5] = '{S_IF, S_ID, S_EX, S_IF, S_ID};
    logic [11:0] nc [5] = '{CW_IF_RDY, CW_ZERO, CW_PC4, CW_IF_RDY, CW_ZERO};
    apply_reset(); opcode = 7'b1111111; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i] || fault !== ef[i]) begin
        bad++; $display("FAIL illegal_halt cyc=%0d state=%0d ctrl=%03h f=%b expected state=%0d ctrl=%03h f=%b", i, state, obs, fault, es[i], ec[i], ef[i]);
      end
      total++;
      if (n_state !== ns[i] || obs_n !== nc[i] || n_fault !== 1'b0) begin
        bad++; $display("FAIL illegal_nop cyc=%0d state=%0d ctrl=%03h f=%b expected state=%0d ctrl=%03h f=0", i, n_state, obs_n, n_fault, ns[i], nc[i]);
      end
      @(posedge clk); #1;
    end
    $display("illegal: FAULT when halting, PC+4 NOP otherwise");
  endtask

  task automatic test_timeout(input logic rescue);
    state_t      es [5];
    logic [11:0] ec [5];
    logic        ef [5];
    if (rescue) begin
      es = '{S_IF, S_IF, S_IF, S_IF, S_ID};
      ec = '{CW_IF_WAIT, CW_IF_WAIT, CW_IF_WAIT, CW_IF_RDY, CW_ZERO};
      ef = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      es = '{S_IF, S_IF, S_IF, S_IF, S_FAULT};
      ec = '{CW_IF_WAIT, CW_IF_WAIT, CW_IF_WAIT, CW_IF_WAIT, CW_ZERO};
      ef = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    end
    apply_reset(); opcode = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 3) ? rescue : 1'b0;
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i] || fault !== ef[i]) begin
        bad++; $display("FAIL timeout_r%0d cyc=%0d state=%0d ctrl=%03h f=%b expected state=%0d ctrl=%03h f=%b", rescue, i, state, obs, fault, es[i], ec[i], ef[i]);
      end
      @(posedge clk); #1;
    end
    $display("timeout rescue=%0d: 4 IF wait cycles", rescue);
  endtask

  task automatic test_reset_mid_store();
    apply_reset(); opcode = 7'b0100011; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk); total++;
    if (state !== S_MEM || obs !== CW_ST_WAIT) begin
      bad++; $display("FAIL mid_store_pre state=%0d ctrl=%03h expected state=%0d ctrl=%03h", state, obs, S_MEM, CW_ST_WAIT);
    end
    #2 reset = 1'b1; #1;
    total++;
    if (state !== S_IF || obs !== CW_IF_WAIT) begin
      bad++; $display("FAIL mid_store_async state=%0d ctrl=%03h expected state=%0d ctrl=%03h", state, obs, S_IF, CW_IF_WAIT);
    end
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if (state !== S_IF || mem_write !== 1'b0 || fault !== 1'b0) begin
        bad++; $display("FAIL mid_store_after cyc=%0d state=%0d mem_write=%b f=%b expected state=%0d mem_write=0 f=0", i, state, mem_write, fault, S_IF);
      end
      @(posedge clk); #1;
    end
    $display("reset mid-store: store abandoned, back in IF");
  endtask

  task automatic test_back_to_back();
    state_t      es [8] = '{S_IF, S_ID, S_EX, S_WB, S_IF, S_ID, S_EX, S_IF};
    logic [11:0] ec [8] = '{CW_IF_RDY, CW_ZERO, CW_EX_R, CW_WB_ALU, CW_IF_RDY, CW_ZERO, CW_BR_TAKEN, CW_IF_RDY};
    apply_reset(); mem_ready = 1'b1; bcond = 1'b1;
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 4) ? 7'b0110011 : 7'b1100011;
      @(negedge clk); total++;
      if (state !== es[i] || obs !== ec[i]) begin
        bad++; $display("FAIL b2b cyc=%0d state=%0d ctrl=%03h expected state=%0d ctrl=%03h", i, state, obs, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
    bcond = 1'b0;
    $display("back-to-back: R-type followed by taken branch");
  endtask

  initial begin
    test_reset();
    test_alu(7'b0110011, CW_EX_R, "rtype");
    test_alu(7'b0010011, CW_EX_I, "itype");
    test_load_wait();
    test_store();
    test_branch(1'b1, CW_BR_TAKEN);
    test_branch(1'b0, CW_PC4);
    test_jump(7'b1101111, CW_WB_JAL, "jal");
    test_jump(7'b1100111, CW_WB_JALR, "jalr");
    test_ecall();
    test_illegal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_store();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
